// File: rtl/seg_display_ctrl.sv
// Multi-digit hex seven-segment driver with leading-zero blanking,
// a free-running tick divider and a display blink overlay.
module seg_display_ctrl #(
    parameter int DIGITS = 4,
    parameter int DIV    = 10000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data_in,
    input  logic                  blank_lz,
    input  logic                  blink_en,
    output logic [7*DIGITS-1:0]   seg_out,
    output logic                  tick
);

    localparam int            CW        = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
    localparam logic [6:0]    SEG_BLANK = 7'h7F;
    localparam logic [6:0]    SEG_ZERO  = 7'h40;

    logic [4*DIGITS-1:0] value_q;
    logic                mode_q;
    logic [CW-1:0]       cnt_q;
    logic                phase_q;
    logic                wrap;
    logic [DIGITS-1:0]   upper_zero;
    logic [7*DIGITS-1:0] seg_next;

    // Active-high gfedcba pattern for one hex nibble.
    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        logic [6:0] code;
        case (nib)
            4'h0: code = 7'h3F;
            4'h1: code = 7'h06;
            4'h2: code = 7'h5B;
            4'h3: code = 7'h4F;
            4'h4: code = 7'h66;
            4'h5: code = 7'h6D;
            4'h6: code = 7'h7D;
            4'h7: code = 7'h07;
            4'h8: code = 7'h7F;
            4'h9: code = 7'h67;
            4'hA: code = 7'h77;
            4'hB: code = 7'h7C;
            4'hC: code = 7'h58;
            4'hD: code = 7'h5E;
            4'hE: code = 7'h79;
            default: code = 7'h71;
        endcase
        return code;
    endfunction

    assign wrap = (cnt_q == CNT_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            tick  <= 1'b0;
        end else begin
            cnt_q <= wrap ? '0 : cnt_q + CW'(1);
            tick  <= wrap;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q <= 1'b0;
        end else if (!blink_en) begin
            phase_q <= 1'b0;
        end else if (wrap) begin
            phase_q <= ~phase_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value_q <= '0;
            mode_q  <= 1'b0;
        end else if (load) begin
            value_q <= data_in;
            mode_q  <= blank_lz;
        end
    end

    // upper_zero[i] is set when nibbles i..DIGITS-1 of the stored value are all zero.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the block can infer a latch.
        upper_zero             = '0;
        upper_zero[DIGITS-1]   = (value_q[4*(DIGITS-1) +: 4] == 4'h0);
        for (int i = DIGITS - 2; i >= 0; i--) begin
            upper_zero[i] = upper_zero[i+1] && (value_q[4*i +: 4] == 4'h0);
        end
    end

    // Blink blank takes priority over leading-zero suppression and decode.
    always_comb begin
        seg_next = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (blink_en && phase_q) begin
                seg_next[7*i +: 7] = SEG_BLANK;
            end else if (mode_q && (i != 0) && upper_zero[i]) begin
                seg_next[7*i +: 7] = SEG_BLANK;
            end else begin
                seg_next[7*i +: 7] = ~hex_decode(value_q[4*i +: 4]);
            end
        end
    end

    // NOTE: the output register is reset to the pattern a cleared value
    // decodes to, so the display reads "0" rather than dark during reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg_out <= {DIGITS{SEG_ZERO}};
        end else begin
            seg_out <= seg_next;
        end
    end

endmodule

// File: doc/seg_display_ctrl.md
SEG_DISPLAY_CTRL -- requirements
Module: seg_display_ctrl

Interface
REQ-001 Parameter DIGITS, default 4: number of hex digits driven; legal range 1..8.
REQ-002 Parameter DIV, default 10000000: blink half-period and tick period in clk cycles; legal minimum 2.
REQ-003 Port clk, input, 1: the block's only clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1: reset; asynchronous, active-low.
REQ-005 Port load, input, 1: capture strobe for data_in and blank_lz.
REQ-006 Port data_in, input, 4*DIGITS: value to display; nibble i, bits [4i+3:4i], maps to digit i; digit 0 is least significant.
REQ-007 Port blank_lz, input, 1: leading-zero suppression mode; sampled only with load.
REQ-008 Port blink_en, input, 1: level; when 1, the display flashes with half-period DIV.
REQ-009 Port seg_out, output, 7*DIGITS: registered, active-low segments; digit i at [7i+6:7i], bit order gfedcba.
REQ-010 Port tick, output, 1: registered one-cycle pulse, once every DIV cycles.

Function
REQ-011 On a rising clk edge with load=1, the block shall capture data_in into an internal value register and blank_lz into an internal mode register.
REQ-012 seg_out shall reflect a captured value on the rising edge after capture, giving a load-to-display latency of 2 edges.
REQ-013 Decode shall be active-high gfedcba before inversion: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=67, A=77, B=7C, C=58, D=5E, E=79, F=71.
REQ-014 Each seg_out digit shall carry the bitwise inverse of its decoded code.
REQ-015 With the mode register at 1, digit i (i>=1) shall be blank (7'h7F) when stored nibbles i..DIGITS-1 are all zero.
REQ-016 Digit 0 shall never be suppressed.
REQ-017 The divider counter shall count 0..DIV-1 and wrap to 0; it shall be free-running and independent of load and blink_en.
REQ-018 tick shall be 1 for exactly the one cycle following each edge on which the counter is at DIV-1.
REQ-019 A phase bit shall toggle on each counter wrap while blink_en=1.
REQ-020 The phase bit shall be forced to 0 on any edge where blink_en=0.
REQ-021 When blink_en=1 and phase=1, every digit of seg_out shall be 7'h7F.
REQ-022 When phase=0, seg_out shall show the normal decode.
REQ-023 Blank state shall take effect on seg_out one edge after phase changes.
REQ-024 When load and a counter wrap occur on the same edge, both shall take effect: the value updates and the phase toggles.
REQ-025 The blink blank shall override both the decode and leading-zero suppression.
REQ-026 load held high for multiple cycles shall recapture every cycle; the last captured value wins.
REQ-027 The design shall have no combinational path from any input to seg_out or tick.

Reset
REQ-028 While rst=0, the value register, mode register, counter and phase shall be 0, and tick shall be 0.
REQ-029 While rst=0, every seg_out digit shall be 7'h40 (digit "0").
REQ-030 Reset asserted mid-blink or mid-count shall clear all state immediately, without waiting for a clock edge.
REQ-031 After rst releases, counting shall restart from 0 and the first tick shall occur DIV edges later.

Verification (DIGITS=4, DIV=4)
REQ-032 Reset release, no load -> seg_out = {4{7'h40}}, and tick pulses on edges 4, 8, 12 after release.
REQ-033 load=1 with data_in=16'h3A0F, blank_lz=0 -> after 2 edges, seg_out digits 3..0 = 7'h30, 7'h08, 7'h40, 7'h0E.
REQ-034 load with data_in=16'h0005, blank_lz=1 -> digits 3..1 = 7'h7F and digit 0 = 7'h12; then load 16'h0000, blank_lz=1 -> digits 3..1 = 7'h7F and digit 0 = 7'h40.
REQ-035 blink_en=1 with value 16'h1234 -> seg_out alternates between all 7'h7F and the decode every 4 cycles; dropping blink_en during the blank half restores the decode on the next edge.
REQ-036 load coincident with a counter wrap while blink_en=1 -> new value captured and phase toggled on the same edge; the digits show the new value in the next unblanked half.
REQ-037 rst pulsed low asynchronously mid-blink-blank -> seg_out = {4{7'h40}} without a clock edge, and tick stays 0 until 4 edges after release.
